// File: rtl/control_unit_if.sv
// Datapath control bundle between the multicycle control FSM (master) and the datapath (slave).
interface control_unit_if;
  logic [6:0]  opcode_i;
  logic        mem_ready_i;
  logic        pc_write_o;
  logic        pc_write_cond_o;
  logic        ir_write_o;
  logic        reg_write_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        iord_o;
  logic        is_immediate_o;
  logic        pc_source_o;
  logic [1:0]  alu_op_o;
  logic [1:0]  alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  mem_to_reg_o;
  logic [3:0]  state_o;
  logic        illegal_o;
  logic [31:0] retire_count_o;

  modport master (
    input  opcode_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o, mem_read_o,
           mem_write_o, iord_o, is_immediate_o, pc_source_o, alu_op_o,
           alu_src_a_o, alu_src_b_o, mem_to_reg_o, state_o, illegal_o,
           retire_count_o
  );

  modport slave (
    output opcode_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, ir_write_o, reg_write_o, mem_read_o,
           mem_write_o, iord_o, is_immediate_o, pc_source_o, alu_op_o,
           alu_src_a_o, alu_src_b_o, mem_to_reg_o, state_o, illegal_o,
           retire_count_o
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle RV32 control FSM: decodes the IR opcode into per-state datapath controls
// and counts retired instructions.
module control_unit (
  input  logic           clk_i,
  input  logic           rst_i,
  control_unit_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE  = 4'd1,  S_MEMADR = 4'd2,  S_MEMREAD = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5, S_EXECR  = 4'd6,  S_EXECI   = 4'd7,
    S_ALUWB    = 4'd8,  S_BRANCH  = 4'd9,  S_JAL    = 4'd10, S_JALR    = 4'd11,
    S_LUI      = 4'd12, S_AUIPC   = 4'd13
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retire_count;
  logic        w_retire;
  logic        w_pc_write, w_pc_write_cond, w_ir_write, w_reg_write;
  logic        w_mem_read, w_mem_write, w_iord, w_is_imm, w_pc_source, w_illegal;
  logic [1:0]  w_alu_op, w_src_a, w_src_b, w_mem_to_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state        <= S_FETCH;
      r_retire_count <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retire_count <= r_retire_count + 32'd1;
    end
  end

  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_ir_write      = 1'b0;
    w_reg_write     = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_iord          = 1'b0;
    w_is_imm        = 1'b0;
    w_pc_source     = 1'b0;
    w_illegal       = 1'b0;
    w_alu_op        = 2'b00;
    w_src_a         = 2'b00;
    w_src_b         = 2'b00;
    w_mem_to_reg    = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_src_b    = 2'b01;
        if (bus.mem_ready_i) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: begin
        // Speculatively form PC-relative target into ALUOut for branch/JAL.
        w_src_a = 2'b10;
        w_src_b = 2'b10;
        case (bus.opcode_i)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default: begin
            w_illegal = 1'b1;
            w_next    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        w_src_a = 2'b01;
        w_src_b = 2'b10;
        w_next  = (bus.opcode_i == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
        if (bus.mem_ready_i) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b01;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
        if (bus.mem_ready_i) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXECR: begin
        w_src_a = 2'b01;
        w_alu_op = 2'b10;
        w_next   = S_ALUWB;
      end
      S_EXECI: begin
        w_src_a  = 2'b01;
        w_src_b  = 2'b10;
        w_alu_op = 2'b11;
        w_is_imm = 1'b1;
        w_next   = S_ALUWB;
      end
      S_LUI: begin
        w_src_a = 2'b11;
        w_src_b = 2'b10;
        w_next  = S_ALUWB;
      end
      S_AUIPC: begin
        w_src_a = 2'b10;
        w_src_b = 2'b10;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a         = 2'b01;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 1'b1;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end
      S_JAL: begin
        w_pc_write   = 1'b1;
        w_pc_source  = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b10;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_JALR: begin
        w_src_a      = 2'b01;
        w_src_b      = 2'b10;
        w_pc_write   = 1'b1;
        w_reg_write  = 1'b1;
        w_mem_to_reg = 2'b10;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Architectural write strobes are suppressed during reset so no state is corrupted.
  assign bus.pc_write_o      = w_pc_write      & ~rst_i;
  assign bus.pc_write_cond_o = w_pc_write_cond & ~rst_i;
  assign bus.ir_write_o      = w_ir_write      & ~rst_i;
  assign bus.reg_write_o     = w_reg_write     & ~rst_i;
  assign bus.mem_write_o     = w_mem_write     & ~rst_i;
  assign bus.illegal_o       = w_illegal       & ~rst_i;
  assign bus.mem_read_o      = w_mem_read;
  assign bus.iord_o          = w_iord;
  assign bus.is_immediate_o  = w_is_imm;
  assign bus.pc_source_o     = w_pc_source;
  assign bus.alu_op_o        = w_alu_op;
  assign bus.alu_src_a_o     = w_src_a;
  assign bus.alu_src_b_o     = w_src_b;
  assign bus.mem_to_reg_o    = w_mem_to_reg;
  assign bus.state_o         = r_state;
  assign bus.retire_count_o  = r_retire_count;
endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit: per-cycle state and control-vector checks.
module tb_control_unit;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] exp_retire;

  control_unit_if u_if ();

  control_unit u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  // {pcw, pcwc, irw, regw, mrd, mwr, iord, imm, pcsrc, aluop[2], srca[2], srcb[2], m2r[2], illegal}
  logic [17:0] ctl;
  assign ctl = {u_if.pc_write_o, u_if.pc_write_cond_o, u_if.ir_write_o, u_if.reg_write_o,
                u_if.mem_read_o, u_if.mem_write_o, u_if.iord_o, u_if.is_immediate_o,
                u_if.pc_source_o, u_if.alu_op_o, u_if.alu_src_a_o, u_if.alu_src_b_o,
                u_if.mem_to_reg_o, u_if.illegal_o};

  localparam logic [17:0] C_FETCH1  = 18'b1_0_1_0_1_0_0_0_0_00_00_01_00_0;
  localparam logic [17:0] C_FETCH0  = 18'b0_0_0_0_1_0_0_0_0_00_00_01_00_0;
  localparam logic [17:0] C_DECODE  = 18'b0_0_0_0_0_0_0_0_0_00_10_10_00_0;
  localparam logic [17:0] C_ILLEGAL = 18'b0_0_0_0_0_0_0_0_0_00_10_10_00_1;
  localparam logic [17:0] C_MEMADR  = 18'b0_0_0_0_0_0_0_0_0_00_01_10_00_0;
  localparam logic [17:0] C_MEMREAD = 18'b0_0_0_0_1_0_1_0_0_00_00_00_00_0;
  localparam logic [17:0] C_MEMWB   = 18'b0_0_0_1_0_0_0_0_0_00_00_00_01_0;
  localparam logic [17:0] C_MEMWR   = 18'b0_0_0_0_0_1_1_0_0_00_00_00_00_0;
  localparam logic [17:0] C_MEMWR_R = 18'b0_0_0_0_0_0_1_0_0_00_00_00_00_0;
  localparam logic [17:0] C_EXECR   = 18'b0_0_0_0_0_0_0_0_0_10_01_00_00_0;
  localparam logic [17:0] C_EXECI   = 18'b0_0_0_0_0_0_0_1_0_11_01_10_00_0;
  localparam logic [17:0] C_LUI     = 18'b0_0_0_0_0_0_0_0_0_00_11_10_00_0;
  localparam logic [17:0] C_AUIPC   = 18'b0_0_0_0_0_0_0_0_0_00_10_10_00_0;
  localparam logic [17:0] C_ALUWB   = 18'b0_0_0_1_0_0_0_0_0_00_00_00_00_0;
  localparam logic [17:0] C_BRANCH  = 18'b0_1_0_0_0_0_0_0_1_01_01_00_00_0;
  localparam logic [17:0] C_JAL     = 18'b1_0_0_1_0_0_0_0_1_00_00_00_10_0;
  localparam logic [17:0] C_JALR    = 18'b1_0_0_1_0_0_0_0_0_00_01_10_10_0;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_ADD = 7'b0110011;
  localparam logic [6:0] OP_ADI = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  task automatic test_reset();
    rst = 1'b1;
    u_if.mem_ready_i = 1'b1;
    u_if.opcode_i = OP_ADI;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (u_if.state_o !== 4'd0) begin
      errors++; $display("FAIL reset_state: got %0d expected 0", u_if.state_o);
    end
    checks++;
    if (u_if.retire_count_o !== 32'd0) begin
      errors++; $display("FAIL reset_retire: got %0d expected 0", u_if.retire_count_o);
    end
    checks++;
    if (ctl !== C_FETCH0) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_FETCH0);
    end
    @(negedge clk);
    rst = 1'b0;
    u_if.mem_ready_i = 1'b0;
    exp_retire = 32'd0;
  endtask

  task automatic end_check(input string nm);
    @(negedge clk);
    u_if.mem_ready_i = 1'b0;
    #1;
    checks++;
    if (u_if.state_o !== 4'd0) begin
      errors++; $display("FAIL %s end_state: got %0d expected 0", nm, u_if.state_o);
    end
    checks++;
    if (u_if.retire_count_o !== exp_retire) begin
      errors++; $display("FAIL %s retire: got %0d expected %0d", nm, u_if.retire_count_o, exp_retire);
    end
  endtask

  task automatic test_addi();
    int          st [4]  = '{0, 1, 7, 8};
    bit          rdy [4] = '{1, 1, 1, 1};
    logic [17:0] cv [4]  = '{C_FETCH1, C_DECODE, C_EXECI, C_ALUWB};
    foreach (st[i]) begin
      @(negedge clk);
      u_if.opcode_i = OP_ADI;
      u_if.mem_ready_i = rdy[i];
      #1;
      checks++;
      if (int'(u_if.state_o) !== st[i]) begin
        errors++; $display("FAIL addi state[%0d]: got %0d expected %0d", i, u_if.state_o, st[i]);
      end
      checks++;
      if (ctl !== cv[i]) begin
        errors++; $display("FAIL addi ctl[%0d]: got %b expected %b", i, ctl, cv[i]);
      end
    end
    exp_retire = exp_retire + 32'd1;
    end_check("addi");
  endtask

  task automatic test_load_wait();
    int          st [8]  = '{0, 1, 2, 3, 3, 3, 3, 4};
    bit          rdy [8] = '{1, 1, 1, 0, 0, 0, 1, 0};
    logic [17:0] cv [8]  = '{C_FETCH1, C_DECODE, C_MEMADR, C_MEMREAD,
                             C_MEMREAD, C_MEMREAD, C_MEMREAD, C_MEMWB};
    foreach (st[i]) begin
      @(negedge clk);
      u_if.opcode_i = OP_LW;
      u_if.mem_ready_i = rdy[i];
      #1;
      checks++;
      if (int'(u_if.state_o) !== st[i]) begin
        errors++; $display("FAIL lw state[%0d]: got %0d expected %0d", i, u_if.state_o, st[i]);
      end
      checks++;
      if (ctl !== cv[i]) begin
        errors++; $display("FAIL lw ctl[%0d]: got %b expected %b", i, ctl, cv[i]);
      end
    end
    exp_retire = exp_retire + 32'd1;
    end_check("lw");
  endtask

  task automatic test_store_fetch_wait();
    int          st [6]  = '{0, 0, 0, 1, 2, 5};
    bit          rdy [6] = '{0, 0, 1, 0, 0, 1};
    logic [17:0] cv [6]  = '{C_FETCH0, C_FETCH0, C_FETCH1, C_DECODE, C_MEMADR, C_MEMWR};
    foreach (st[i]) begin
      @(negedge clk);
      u_if.opcode_i = OP_SW;
      u_if.mem_ready_i = rdy[i];
      #1;
      checks++;
      if (int'(u_if.state_o) !== st[i]) begin
        errors++; $display("FAIL sw state[%0d]: got %0d expected %0d", i, u_if.state_o, st[i]);
      end
      checks++;
      if (ctl !== cv[i]) begin
        errors++; $display("FAIL sw ctl[%0d]: got %b expected %b", i, ctl, cv[i]);
      end
    end
    exp_retire = exp_retire + 32'd1;
    end_check("sw");
  endtask

  task automatic test_illegal();
    int          st [2]  = '{0, 1};
    bit          rdy [2] = '{1, 1};
    logic [17:0] cv [2]  = '{C_FETCH1, C_ILLEGAL};
    foreach (st[i]) begin
      @(negedge clk);
      u_if.opcode_i = OP_BAD;
      u_if.mem_ready_i = rdy[i];
      #1;
      checks++;
      if (int'(u_if.state_o) !== st[i]) begin
        errors++; $display("FAIL illegal state[%0d]: got %0d expected %0d", i, u_if.state_o, st[i]);
      end
      checks++;
      if (ctl !== cv[i]) begin
        errors++; $display("FAIL illegal ctl[%0d]: got %b expected %b", i, ctl, cv[i]);
      end
    end
    end_check("illegal");
  endtask

  task automatic test_jumps();
    int          st [9]  = '{0, 1, 10, 0, 1, 11, 0, 1, 9};
    logic [6:0]  op [9]  = '{OP_JAL, OP_JAL, OP_JAL, OP_JLR, OP_JLR, OP_JLR,
                             OP_BEQ, OP_BEQ, OP_BEQ};
    logic [17:0] cv [9]  = '{C_FETCH1, C_DECODE, C_JAL, C_FETCH1, C_DECODE, C_JALR,
                             C_FETCH1, C_DECODE, C_BRANCH};
    foreach (st[i]) begin
      @(negedge clk);
      u_if.opcode_i = op[i];
      u_if.mem_ready_i = 1'b1;
      #1;
      checks++;
      if (int'(u_if.state_o) !== st[i]) begin
        errors++; $display("FAIL jumps state[%0d]: got %0d expected %0d", i, u_if.state_o, st[i]);
      end
      checks++;
      if (ctl !== cv[i]) begin
        errors++; $display("FAIL jumps ctl[%0d]: got %b expected %b", i, ctl, cv[i]);
      end
    end
    exp_retire = exp_retire + 32'd3;
    end_check("jumps");
  endtask

  task automatic test_back_to_back();
    int          st [12] = '{0, 1, 12, 8, 0, 1, 13, 8, 0, 1, 6, 8};
    logic [6:0]  op [12] = '{OP_LUI, OP_LUI, OP_LUI, OP_LUI, OP_AUI, OP_AUI, OP_AUI, OP_AUI,
                             OP_ADD, OP_ADD, OP_ADD, OP_ADD};
    logic [17:0] cv [12] = '{C_FETCH1, C_DECODE, C_LUI, C_ALUWB, C_FETCH1, C_DECODE, C_AUIPC,
                             C_ALUWB, C_FETCH1, C_DECODE, C_EXECR, C_ALUWB};
    foreach (st[i]) begin
      @(negedge clk);
      u_if.opcode_i = op[i];
      u_if.mem_ready_i = 1'b1;
      #1;
      checks++;
      if (int'(u_if.state_o) !== st[i]) begin
        errors++; $display("FAIL b2b state[%0d]: got %0d expected %0d", i, u_if.state_o, st[i]);
      end
      checks++;
      if (ctl !== cv[i]) begin
        errors++; $display("FAIL b2b ctl[%0d]: got %b expected %b", i, ctl, cv[i]);
      end
    end
    exp_retire = exp_retire + 32'd3;
    end_check("b2b");
  endtask

  task automatic test_reset_mid_store();
    int          st [3]  = '{0, 1, 2};
    logic [17:0] cv [3]  = '{C_FETCH1, C_DECODE, C_MEMADR};
    foreach (st[i]) begin
      @(negedge clk);
      u_if.opcode_i = OP_SW;
      u_if.mem_ready_i = 1'b1;
      #1;
      checks++;
      if (int'(u_if.state_o) !== st[i]) begin
        errors++; $display("FAIL rst_sw state[%0d]: got %0d expected %0d", i, u_if.state_o, st[i]);
      end
      checks++;
      if (ctl !== cv[i]) begin
        errors++; $display("FAIL rst_sw ctl[%0d]: got %b expected %b", i, ctl, cv[i]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    u_if.mem_ready_i = 1'b1;
    #1;
    checks++;
    if (u_if.state_o !== 4'd5) begin
      errors++; $display("FAIL rst_sw memwrite_state: got %0d expected 5", u_if.state_o);
    end
    checks++;
    if (ctl !== C_MEMWR_R) begin
      errors++; $display("FAIL rst_sw forced_ctl: got %b expected %b", ctl, C_MEMWR_R);
    end
    @(negedge clk);
    rst = 1'b0;
    u_if.mem_ready_i = 1'b0;
    #1;
    exp_retire = 32'd0;
    checks++;
    if (u_if.state_o !== 4'd0) begin
      errors++; $display("FAIL rst_sw after_state: got %0d expected 0", u_if.state_o);
    end
    checks++;
    if (u_if.retire_count_o !== exp_retire) begin
      errors++; $display("FAIL rst_sw retire: got %0d expected 0", u_if.retire_count_o);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    checks = 0;
    errors = 0;
    exp_retire = 32'd0;
    u_if.opcode_i = 7'd0;
    u_if.mem_ready_i = 1'b0;
    test_reset();
    test_addi();
    test_load_wait();
    test_store_fetch_wait();
    test_illegal();
    test_jumps();
    test_back_to_back();
    test_reset_mid_store();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
